// File: rtl/receive_module.sv
// rtl/receive_module.sv - UART receiver: 16x oversampled, 8 data bits, even parity, one stop bit.
// Delivers each byte with parity/framing flags; a held-low line after a bad stop is parked in BREAK.
module receive_module #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       baud_tick,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_BUSY,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perror_q, perror_d;
  logic                   ferror_q, ferror_d;
  logic                   rxs;
  logic                   in_frame;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perror_d = perror_q;
    ferror_d = ferror_q;

    if (!Rx_EN && in_frame) begin
      // Disable drops the frame immediately; delivered outputs stay as they were.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (baud_tick && Rx_EN && !rxs) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (tick_q == TICK_MID) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = rxs ? S_IDLE : S_DATA;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_d          = '0;
              shift_d[bit_q]  = rxs;
              if (bit_q == 3'd7) state_d = S_PARITY;
              else               bit_d   = bit_q + 3'd1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_d  = '0;
              perr_d  = rxs ^ (^shift_q);
              state_d = S_STOP;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (tick_q == TICK_LAST) begin
              // Leaving mid stop bit lets a back-to-back start edge be caught.
              tick_d   = '0;
              data_d   = shift_q;
              perror_d = perr_q;
              ferror_d = ~rxs;
              valid_d  = 1'b1;
              state_d  = rxs ? S_IDLE : S_BREAK;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (baud_tick && rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sync_q   <= '1;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perror_q <= 1'b0;
      ferror_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], RxD};
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perror_q <= perror_d;
      ferror_q <= ferror_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_BUSY   = in_frame;
  assign Rx_PERROR = perror_q;
  assign Rx_FERROR = ferror_q;

endmodule

// File: tb/tb_receive_module.sv
// tb/tb_receive_module.sv - randomized frames checked against a queue-based receiver model.
module tb_receive_module;
  localparam int OS       = 16;
  localparam int TICK_DIV = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_BUSY, Rx_PERROR, Rx_FERROR;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];  // {ferr, perr, data} of frames whose delivery is owed

  receive_module #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .Rx_EN(Rx_EN), .RxD(RxD), .baud_tick(baud_tick),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_BUSY(Rx_BUSY),
    .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
  );

  initial forever #5 clock = ~clock;

  initial begin
    int div = 0;
    forever begin
      @(posedge clock);
      #1;
      baud_tick = (div == TICK_DIV - 1);
      div = (div + 1) % TICK_DIV;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clock);
      if (baud_tick) c++;
    end
    #2;
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop);
    logic p;
    p = (^d) ^ flip;
    exp_q.push_back({~stop, p ^ (^d), d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    chk("missed_valid", exp_q.size(), 0);
  endtask

  // Model: outputs hold the last delivered frame; each VALID consumes one owed frame.
  initial begin
    logic [7:0] hd = 8'h00;
    logic       hp = 1'b0, hf = 1'b0, pv = 1'b0, r;
    forever begin
      @(posedge clock);
      r = reset;
      @(negedge clock);
      if (!r) begin
        hd = 8'h00; hp = 1'b0; hf = 1'b0;
        exp_q.delete();
        chk("reset_valid", Rx_VALID, 0);
        chk("reset_busy", Rx_BUSY, 0);
      end else if (Rx_VALID) begin
        chk("valid_width", pv, 0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid actual=1 required=0");
        end else begin
          {hf, hp, hd} = exp_q.pop_front();
        end
      end
      chk("data", Rx_DATA, hd);
      chk("perror", Rx_PERROR, hp);
      chk("ferror", Rx_FERROR, hf);
      pv = Rx_VALID;
    end
  end

  initial begin
    logic [7:0] d;
    bit flip, stop;
    int idle;

    repeat (4) @(posedge clock);
    #2;
    chk("rst_data", Rx_DATA, 8'h00);
    chk("rst_busy", Rx_BUSY, 0);
    chk("rst_valid", Rx_VALID, 0);
    reset = 1'b1;
    send_bit(1'b1);

    send_frame(8'hA5, 0, 1);
    chk("t1_data", Rx_DATA, 8'hA5);
    chk("t1_perr", Rx_PERROR, 0);
    chk("t1_ferr", Rx_FERROR, 0);
    send_bit(1'b1);

    send_frame(8'h01, 1, 1);
    chk("t2_data", Rx_DATA, 8'h01);
    chk("t2_perr", Rx_PERROR, 1);
    chk("t2_ferr", Rx_FERROR, 0);
    send_bit(1'b1);

    send_frame(8'h3C, 0, 0);
    chk("t3_data", Rx_DATA, 8'h3C);
    chk("t3_ferr", Rx_FERROR, 1);
    wait_ticks(40 * OS);
    chk("t3_break_busy", Rx_BUSY, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h55, 0, 1);
    chk("t3_data2", Rx_DATA, 8'h55);
    chk("t3_ferr2", Rx_FERROR, 0);
    send_bit(1'b1);

    RxD = 1'b0;
    wait_ticks(2);
    chk("t4_busy_hi", Rx_BUSY, 1);
    wait_ticks(3);
    RxD = 1'b1;
    wait_ticks(20);
    chk("t4_busy_lo", Rx_BUSY, 0);

    send_frame(8'hFF, 0, 1);
    chk("t5_data1", Rx_DATA, 8'hFF);
    send_frame(8'h00, 0, 1);
    chk("t5_data2", Rx_DATA, 8'h00);
    chk("t5_perr", Rx_PERROR, 0);
    chk("t5_ferr", Rx_FERROR, 0);
    send_bit(1'b1);

    for (int k = 0; k < 25; k++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(3) == 0);
      stop = ($urandom_range(7) != 0);
      send_frame(d, flip, stop);
      idle = stop ? $urandom_range(2) : 1 + $urandom_range(1);
      repeat (idle) send_bit(1'b1);
    end

    send_frame(8'h96, 1, 1);
    send_bit(1'b1);
    chk("t6_pre_data", Rx_DATA, 8'h96);
    chk("t6_pre_perr", Rx_PERROR, 1);
    d = 8'h6B;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    RxD = d[3];
    wait_ticks(4);
    Rx_EN = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("t6_abort_busy", Rx_BUSY, 0);
    RxD = 1'b1;
    wait_ticks(8 * OS);
    chk("t6_abort_data", Rx_DATA, 8'h96);
    chk("t6_abort_perr", Rx_PERROR, 1);
    Rx_EN = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t6_busy_mid", Rx_BUSY, 1);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("t6_rst_data", Rx_DATA, 8'h00);
    chk("t6_rst_perr", Rx_PERROR, 0);
    chk("t6_rst_busy", Rx_BUSY, 0);
    RxD = 1'b1;
    reset = 1'b1;
    wait_ticks(2 * OS);
    chk("t6_idle_busy", Rx_BUSY, 0);
    send_frame(8'h5A, 0, 1);
    chk("t6_recover", Rx_DATA, 8'h5A);
    send_bit(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
